// File: rtl/prime_sweep.sv
`default_nettype none
// ============================================================================
// prime_sweep : sweeps [lo, hi] through is_prime, forwards primes, counts them.
// Option PRIME_SWEEP_SKIP_EVEN_EN : even candidates other than 2 are not issued.
// Revision    : 1.0
// ============================================================================
module prime_sweep #(
    parameter int WIDTH     = 16,
    parameter int TAG_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_lo,
    input  logic [WIDTH-1:0] cmd_hi,
    output logic             chk_valid,
    input  logic             chk_ready,
    output logic [WIDTH-1:0] chk_number,
    input  logic             chk_result,
    input  logic             chk_rvalid,
    output logic             chk_rready,
    output logic             prime_valid,
    input  logic             prime_ready,
    output logic [WIDTH-1:0] prime_number,
    output logic             done,
    output logic [WIDTH-1:0] prime_count
);
    localparam int          AW      = $clog2(TAG_DEPTH);
    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_ISSUE = 2'd1;
    localparam logic [1:0]  S_DRAIN = 2'd2;
    localparam logic [AW:0] C_FULL  = (AW+1)'(TAG_DEPTH);

    logic [1:0]       r_state, w_state_nxt;
    logic             r_init;
    logic [WIDTH-1:0] r_hi, r_cur, r_pnum, r_count;
    logic             r_pvalid, r_done;
    logic [WIDTH-1:0] r_tags [TAG_DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_cnt;

    logic             w_full, w_empty, w_cmd_acc, w_push, w_pop, w_load;
    logic             w_pv_nxt, w_fifo_empty_nxt, w_drain_exit, w_empty_range, w_last;
    logic [WIDTH-1:0] w_first;
    logic [WIDTH:0]   w_step, w_next_wide;

`ifdef PRIME_SWEEP_SKIP_EVEN_EN
    assign w_first = (!cmd_lo[0] && (cmd_lo > WIDTH'(2))) ? cmd_lo + WIDTH'(1) : cmd_lo;
    // 0 -> 1 -> 2 -> 3 step by one; from any odd above 1 step by two
    assign w_step  = (r_cur[0] && (r_cur != WIDTH'(1))) ? (WIDTH+1)'(2) : (WIDTH+1)'(1);
`else
    assign w_first = cmd_lo;
    assign w_step  = (WIDTH+1)'(1);
`endif

    assign w_full           = (r_cnt == C_FULL);
    assign w_empty          = (r_cnt == '0);
    assign w_cmd_acc        = cmd_valid && cmd_ready;
    assign w_push           = chk_valid && chk_ready;
    assign w_pop            = chk_rvalid && chk_rready;
    assign w_load           = w_pop && chk_result;
    assign w_empty_range    = (w_first > cmd_hi);
    // Wide compare keeps cur from wrapping when hi is the top of the range
    assign w_next_wide      = {1'b0, r_cur} + w_step;
    assign w_last           = (w_next_wide > {1'b0, r_hi});
    assign w_pv_nxt         = w_load || (r_pvalid && !prime_ready);
    assign w_fifo_empty_nxt = w_empty || ((r_cnt == (AW+1)'(1)) && w_pop);
    assign w_drain_exit     = w_fifo_empty_nxt && !w_pv_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_cmd_acc && !w_empty_range) w_state_nxt = S_ISSUE;
            S_ISSUE: if (w_push && w_last)            w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drain_exit)                w_state_nxt = S_IDLE;
            default:                                  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = r_init && (r_state == S_IDLE);
        chk_valid  = (r_state == S_ISSUE) && !w_full;
        chk_rready = !w_empty && (!r_pvalid || prime_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_cur    <= '0;
            r_count  <= '0;
            r_pvalid <= 1'b0;
            r_pnum   <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_cnt    <= '0;
        end else begin
            r_init <= 1'b1;
            r_done <= (w_cmd_acc && w_empty_range) || ((r_state == S_DRAIN) && w_drain_exit);
            if (w_cmd_acc) begin
                r_hi    <= cmd_hi;
                r_cur   <= w_first;
                r_count <= '0;
            end else if (w_push && !w_last) begin
                r_cur <= w_next_wide[WIDTH-1:0];
            end
            if (w_load) begin
                r_pvalid <= 1'b1;
                r_pnum   <= r_tags[r_rptr];
                if (r_count != '1) r_count <= r_count + WIDTH'(1);
            end else if (prime_ready) begin
                r_pvalid <= 1'b0;
            end
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_tags[r_wptr] <= r_cur;
    end

    assign chk_number   = r_cur;
    assign prime_valid  = r_pvalid;
    assign prime_number = r_pnum;
    assign prime_count  = r_count;
    assign done         = r_done;
endmodule
`default_nettype wire

// File: tb/tb_prime_sweep.sv
`default_nettype none
// ============================================================================
// tb_prime_sweep : randomized sweeps against a behavioural prime/candidate model.
// Revision       : 1.0
// ============================================================================
module tb_prime_sweep;
    localparam int WIDTH = 16;
    localparam int LIMIT = 5000;
`ifdef PRIME_SWEEP_SKIP_EVEN_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid, cmd_ready;
    logic [WIDTH-1:0] cmd_lo, cmd_hi;
    logic             chk_valid, chk_ready;
    logic [WIDTH-1:0] chk_number;
    logic             chk_result, chk_rvalid, chk_rready;
    logic             prime_valid, prime_ready;
    logic [WIDTH-1:0] prime_number;
    logic             done;
    logic [WIDTH-1:0] prime_count;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cand[$];
    int exp_primes[$];
    bit chk_q[$];
    bit rv_pend;

    prime_sweep #(.WIDTH(WIDTH), .TAG_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_lo(cmd_lo), .cmd_hi(cmd_hi),
        .chk_valid(chk_valid), .chk_ready(chk_ready), .chk_number(chk_number),
        .chk_result(chk_result), .chk_rvalid(chk_rvalid), .chk_rready(chk_rready),
        .prime_valid(prime_valid), .prime_ready(prime_ready), .prime_number(prime_number),
        .done(done), .prime_count(prime_count)
    );

    always #5 clk = ~clk;

    function automatic bit is_prime_f(input int v);
        if (v < 2) return 1'b0;
        for (int d = 2; d * d <= v; d++) if (v % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check(chk_valid == 1'b0,    "rst_chk_valid",    int'(chk_valid), 0);
        check(chk_rready == 1'b0,   "rst_chk_rready",   int'(chk_rready), 0);
        check(prime_valid == 1'b0,  "rst_prime_valid",  int'(prime_valid), 0);
        check(done == 1'b0,         "rst_done",         int'(done), 0);
        check(prime_count == '0,    "rst_prime_count",  int'(prime_count), 0);
        check(prime_number == '0,   "rst_prime_number", int'(prime_number), 0);
        check(chk_number == '0,     "rst_chk_number",   int'(chk_number), 0);
        check(cmd_ready == 1'b0,    "rst_cmd_ready",    int'(cmd_ready), 0);
    endtask

    // pr_mode: 0 always ready, 1 random, 2 low during cycles 5..25 after accept
    task automatic run_sweep(input int lo, input int hi, input int pr_mode,
                             input int exp_cnt, input int exp_txn, input int abort_at);
        int  cyc, ntxn, last_evt, n_exp;
        bit  got_done, prev_hold;
        int  prev_num, e;
        exp_cand.delete();
        exp_primes.delete();
        for (int v = lo; v <= hi; v++) begin
            if (!SKIP || v <= 2 || (v % 2) == 1) exp_cand.push_back(v);
            if (is_prime_f(v)) exp_primes.push_back(v);
        end
        n_exp = exp_primes.size();

        @(negedge clk);
        cmd_valid = 1'b1; cmd_lo = WIDTH'(lo); cmd_hi = WIDTH'(hi);
        chk_ready = 1'b0; chk_rvalid = 1'b0; chk_result = 1'b0; prime_ready = 1'b1;
        #1;
        check(cmd_ready == 1'b1, "cmd_ready_idle", int'(cmd_ready), 1);

        cyc = 0; ntxn = 0; last_evt = -1; got_done = 0; prev_hold = 0; prev_num = 0;
        while (!got_done && cyc < LIMIT) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            chk_ready = ($urandom % 4) != 0;
            if (chk_q.size() == 0) begin
                chk_rvalid = 1'b0;
                chk_result = 1'(($urandom % 2));
            end else begin
                chk_rvalid = rv_pend || (($urandom % 3) != 0);
                chk_result = chk_q[0];
            end
            case (pr_mode)
                0:       prime_ready = 1'b1;
                1:       prime_ready = ($urandom % 3) != 0;
                default: prime_ready = !(cyc >= 5 && cyc <= 25);
            endcase
            #1;
            if (abort_at > 0 && cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs();
                chk_q.delete();
                rv_pend = 0;
                chk_rvalid = 1'b1; chk_result = 1'b1;
                repeat (2) @(negedge clk);
                #1;
                check(chk_rready == 1'b0, "rst_no_result_accept", int'(chk_rready), 0);
                rst_n = 1'b1;
                chk_rvalid = 1'b0;
                return;
            end
            if (cyc == 0) begin
                if (exp_cand.size() == 0) begin
                    check(chk_valid == 1'b0, "empty_no_issue", int'(chk_valid), 0);
                end else begin
                    check(chk_valid == 1'b1, "first_issue_valid", int'(chk_valid), 1);
                    check(int'(chk_number) == exp_cand[0], "first_issue_number",
                          int'(chk_number), exp_cand[0]);
                end
            end
            if (prev_hold)
                check(prime_valid == 1'b1 && int'(prime_number) == prev_num, "prime_hold",
                      int'(prime_number), prev_num);
            if (prime_valid && !prime_ready)
                check(chk_rready == 1'b0, "rready_when_full", int'(chk_rready), 0);
            if (chk_valid && chk_ready) begin
                e = (exp_cand.size() != 0) ? exp_cand.pop_front() : -1;
                check(int'(chk_number) == e, "issue_number", int'(chk_number), e);
                chk_q.push_back(is_prime_f(int'(chk_number)));
                ntxn++;
            end
            if (chk_rvalid && chk_rready) begin
                void'(chk_q.pop_front());
                last_evt = cyc;
            end
            rv_pend = chk_rvalid && !chk_rready;
            if (prime_valid && prime_ready) begin
                e = (exp_primes.size() != 0) ? exp_primes.pop_front() : -1;
                check(int'(prime_number) == e, "prime_out", int'(prime_number), e);
                last_evt = cyc;
            end
            if (done) begin
                got_done = 1;
                check(exp_cand.size() == 0, "done_all_issued", exp_cand.size(), 0);
                check(exp_primes.size() == 0, "done_all_primes", exp_primes.size(), 0);
                check(int'(prime_count) == n_exp, "done_count_model", int'(prime_count), n_exp);
                if (exp_cnt >= 0)
                    check(int'(prime_count) == exp_cnt, "done_count_lit", int'(prime_count), exp_cnt);
                if (exp_txn >= 0)
                    check(ntxn == exp_txn, "txn_count", ntxn, exp_txn);
                check(cmd_ready == 1'b1, "done_cmd_ready", int'(cmd_ready), 1);
                check(prime_valid == 1'b0, "done_no_pending", int'(prime_valid), 0);
                check(cyc == last_evt + 1, "done_timing", cyc, last_evt + 1);
            end
            prev_hold = prime_valid && !prime_ready;
            prev_num  = int'(prime_number);
            cyc++;
        end
        if (!got_done && abort_at == 0) check(1'b0, "done_timeout", cyc, LIMIT);
    endtask

    initial begin
        int lo, hi;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_lo = '0; cmd_hi = '0;
        chk_ready = 1'b0; chk_result = 1'b0; chk_rvalid = 1'b0; prime_ready = 1'b1;
        rv_pend = 0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;

        run_sweep(2, 10, 0, 4, SKIP ? 5 : 9, 0);
        run_sweep(10, 5, 0, 0, 0, 0);
        run_sweep(2, 30, 2, 10, -1, 0);
        run_sweep(65521, 65535, 1, 1, SKIP ? 8 : 15, 0);
        run_sweep(2, 1000, 1, -1, -1, 40);
        run_sweep(3, 5, 1, 2, SKIP ? 2 : 3, 0);
        run_sweep(1, 20, 1, 8, SKIP ? 11 : 20, 0);
        run_sweep(0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 12; i++) begin
            lo = int'($urandom_range(0, 300));
            hi = (($urandom % 6) == 0) ? lo - int'($urandom_range(1, 3)) : lo + int'($urandom_range(0, 60));
            if (hi < 0) hi = 0;
            run_sweep(lo, hi, 1, -1, -1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/prime_sweep.md
# prime_sweep

Range sweeper and result collector that wraps the `is_prime` checker. It accepts a `[lo, hi]` range command, issues every candidate in ascending order on the checker's input stream, and pairs each in-order checker verdict with its number. It forwards each prime on an output stream and reports the total prime count when the sweep completes. It sits directly upstream and downstream of `is_prime`: its `chk_*` ports connect one-to-one to that block's `valid_i`/`ready_i`/`number` and `result`/`valid_o`/`ready_o`.

## Interface
- `WIDTH`, 16, width of numbers and of the prime count.
- `TAG_DEPTH`, 4, maximum candidates outstanding in the checker (power of two, ≥2).
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `cmd_valid` input 1: range command valid.
- `cmd_ready` output 1: command accepted when both `cmd_valid` and `cmd_ready` are high.
- `cmd_lo` input WIDTH: first candidate, inclusive.
- `cmd_hi` input WIDTH: last candidate, inclusive.
- `chk_valid` output 1: drives `is_prime.valid_i`.
- `chk_ready` input 1: from `is_prime.ready_i`.
- `chk_number` output WIDTH: drives `is_prime.number`.
- `chk_result` input 1: from `is_prime.result`.
- `chk_rvalid` input 1: from `is_prime.valid_o`.
- `chk_rready` output 1: drives `is_prime.ready_o`.
- `prime_valid` output 1: prime output valid.
- `prime_ready` input 1: downstream ready.
- `prime_number` output WIDTH: the prime.
- `done` output 1: one-cycle pulse marking sweep completion.
- `prime_count` output WIDTH: primes found in the last sweep. Valid from `done` until the next command is accepted.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - `cmd_ready`=1.
  - On command accept, latch lo/hi and clear `prime_count`.
  - If lo>hi, pulse `done` next cycle with count 0 and stay in IDLE.
  - Otherwise go to ISSUE with `cur`=lo.
- ISSUE:
  - `chk_valid`=1 while the tag FIFO is not full; `chk_number`=`cur`.
  - On handshake, push `cur` into the tag FIFO.
  - If `cur`==hi, go to DRAIN. Otherwise increment `cur`.
  - Compare against hi before incrementing, so `cur` never wraps (hi=2^WIDTH−1 is legal).
- Result path:
  - `chk_rready` = tag FIFO not empty AND (`prime_valid`==0 OR `prime_ready`==1).
  - On result handshake, pop the FIFO head.
  - If `chk_result`=1, load `prime_number`=head, set `prime_valid`, and increment `prime_count`, saturating at 2^WIDTH−1.
- `prime_valid` holds with stable `prime_number` until `prime_ready`.
- DRAIN: leave when the tag FIFO is empty and (`prime_valid`==0 or it is being accepted). Pulse `done` the same cycle and return to IDLE.
- The checker's results are in order; the tag FIFO is the only number/verdict pairing mechanism.
- Simultaneous push and pop on the tag FIFO are allowed in the same cycle; occupancy is unchanged.
- Reset (any cycle, mid-sweep included):
  - State→IDLE; tag FIFO emptied.
  - `chk_valid`, `chk_rready`, `prime_valid`, `done`=0; `prime_count`, `prime_number`, `chk_number`=0.
  - `cmd_ready`=1 after the first post-reset edge.
  - Results arriving after reset are not accepted, because `chk_rready`=0 with the FIFO empty.

## Timing
- Command accepted at edge N → `chk_valid`=1 with `chk_number`=lo from cycle N+1.
- Peak issue rate is one candidate per cycle.
- Verdict handshake at edge M → `prime_valid` from cycle M+1.
- Last output accept (or last composite verdict) at edge K → `done` high in cycle K+1. `cmd_ready` is high in the same cycle as `done`.
- `chk_valid` drops the cycle after the hi handshake. It never drops mid-transaction without a handshake, except on reset.

## Configuration
- `PRIME_SWEEP_SKIP_EVEN_EN`:
  - Defined: even candidates other than 2 are skipped (never issued), so the issue step becomes +2 after the first odd. Values 0 and 1 are still issued. `cur` must still not exceed hi or wrap.
  - Undefined: every value in [lo, hi] is issued.
  - Prime outputs and count are identical either way.

## Test plan
- Range 2..10, `prime_ready`=1 → primes 2,3,5,7 in order; `done` with `prime_count`=4; 9 checker transactions.
- Range 10..5 → no `chk_valid`; `done` one cycle after the command accept; count 0.
- Range 2..30 with `prime_ready`=0 for cycles 5–25 → no loss or duplication; 10 primes 2..29 in order; `chk_rready` low while the output slot is full.
- Range 65521..65535 → single prime 65521; count 1; `chk_number` never wraps to 0; `done` asserted.
- Reset asserted mid-sweep of 2..1000 → all outputs return to their reset values immediately; a new range 3..5 then yields 3,5 and count 2.
- Range 1..20 → 8 primes; 11 checker transactions with `PRIME_SWEEP_SKIP_EVEN_EN` defined, 20 without.
